// File: rtl/scanner_pkg.sv
// rtl/scanner_pkg.sv - shared types and constants for the USB transmit framer
package scanner_pkg;

   localparam int BYTE_W    = 8;
   localparam int PIX_W     = 16;
   localparam int LINE_NO_W = 16;
   localparam int LEN_W     = 16;

   localparam logic [BYTE_W-1:0] SYNC0 = 8'hA5;
   localparam logic [BYTE_W-1:0] SYNC1 = 8'h5A;

   typedef enum logic [3:0] {
      TX_IDLE,
      TX_SYNC0,
      TX_SYNC1,
      TX_LNH,
      TX_LNL,
      TX_LENH,
      TX_LENL,
      TX_PIXH,
      TX_PIXL,
      TX_CSUM
   } tx_state_t;

endpackage

// File: rtl/pix_fifo.sv
// rtl/pix_fifo.sv - synchronous first-word-fall-through pixel buffer with flush
module pix_fifo #(
   parameter int DEPTH = 1024,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          wr_en,
   input  logic [15:0]   wr_data,
   input  logic          rd_en,
   output logic [15:0]   rd_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   used
);

   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_wr;
   logic          do_rd;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign used    = count;
   assign do_wr   = wr_en && !full && !flush;
   assign do_rd   = rd_en && !empty && !flush;
   // Head word is always visible so the reader sees data in the cycle it pops.
   assign rd_data = mem[rd_ptr];

   // Storage array; no reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      end
   end

endmodule

// File: rtl/usb_tx_framer.sv
// rtl/usb_tx_framer.sv - captures CCD lines and frames them into FT232H transmit bytes
module usb_tx_framer
   import scanner_pkg::*;
#(
   parameter int LINE_PIX   = 5340,
   parameter int FIFO_DEPTH = 1024
) (
   input  logic                 clk_100M,
   input  logic                 nrst,
   input  logic                 en,
   input  logic                 pix_valid,
   input  logic                 pix_sol,
   input  logic [PIX_W-1:0]     pix_data,
   input  logic                 tx_full,
   output logic                 tx_wrreq,
   output logic [BYTE_W-1:0]    tx_data,
   output logic [LINE_NO_W-1:0] lines_sent,
   output logic                 ovf,
   output logic                 sol_err,
   output logic                 busy
);

   localparam int             AW       = $clog2(FIFO_DEPTH);
   localparam logic [LEN_W-1:0] LEN      = LEN_W'(LINE_PIX);
   localparam logic [LEN_W-1:0] LAST_PIX = LEN_W'(LINE_PIX - 1);

   // Buffer signals
   logic              fifo_wr;
   logic              fifo_rd;
   logic [PIX_W-1:0]  fifo_rd_data;
   logic              fifo_full;
   logic              fifo_empty;
   logic [AW:0]       fifo_used;

   // Capture side
   logic              cap_active;
   logic              cap_halt;
   logic [LEN_W-1:0]  cap_cnt;
   logic              cap_req;
   logic              ovf_r;
   logic              sol_err_r;

   // Framer side
   tx_state_t             state, nxt_state;
   logic [BYTE_W-1:0]     data_r, nxt_data;
   logic                  pending, nxt_pend;
   logic [BYTE_W-1:0]     lo_byte, nxt_lo;
   logic [LEN_W-1:0]      pix_cnt, nxt_cnt;
   logic [BYTE_W-1:0]     csum, nxt_csum;
   logic [LINE_NO_W-1:0]  lines_cnt, nxt_lines;
   logic                  do_fetch;
   logic                  wr_now;

   pix_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk_100M),
      .rst_n   (nrst),
      .flush   (!en),
      .wr_en   (fifo_wr),
      .wr_data (pix_data),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .used    (fifo_used)
   );

   // A pixel is wanted when it starts a line or continues one, unless capture is halted by overflow.
   assign cap_req = en && pix_valid && !cap_halt && (cap_active || pix_sol);
   assign fifo_wr = cap_req && !fifo_full;

   // Capture counter: exactly LINE_PIX pixels per line, SOL pixel included.
   always_ff @(posedge clk_100M or negedge nrst) begin
      if (!nrst) begin
         cap_active <= 1'b0;
         cap_halt   <= 1'b0;
         cap_cnt    <= '0;
         ovf_r      <= 1'b0;
         sol_err_r  <= 1'b0;
      end else if (!en) begin
         cap_active <= 1'b0;
         cap_halt   <= 1'b0;
         cap_cnt    <= '0;
      end else if (cap_req) begin
         if (fifo_full) begin
            ovf_r      <= 1'b1;
            cap_halt   <= 1'b1;
            cap_active <= 1'b0;
            cap_cnt    <= '0;
         end else begin
            if (cap_active && pix_sol) sol_err_r <= 1'b1;
            if (cap_cnt == LAST_PIX) begin
               cap_active <= 1'b0;
               cap_cnt    <= '0;
            end else begin
               cap_active <= 1'b1;
               cap_cnt    <= cap_cnt + LEN_W'(1);
            end
         end
      end
   end

   assign wr_now = pending && !tx_full;

   // Framer state register and the byte presented to the transmit FIFO.
   always_ff @(posedge clk_100M or negedge nrst) begin
      if (!nrst) begin
         state     <= TX_IDLE;
         data_r    <= '0;
         pending   <= 1'b0;
         lo_byte   <= '0;
         pix_cnt   <= '0;
         csum      <= '0;
         lines_cnt <= '0;
      end else begin
         state     <= nxt_state;
         data_r    <= nxt_data;
         pending   <= nxt_pend;
         lo_byte   <= nxt_lo;
         pix_cnt   <= nxt_cnt;
         csum      <= nxt_csum;
         lines_cnt <= nxt_lines;
      end
   end

   // Next state: advance only on an accepted byte; PIXH entry pops a pixel or waits for one.
   always_comb begin
      nxt_state = state;
      nxt_data  = data_r;
      nxt_pend  = pending;
      nxt_lo    = lo_byte;
      nxt_cnt   = pix_cnt;
      nxt_csum  = csum;
      nxt_lines = lines_cnt;
      do_fetch  = 1'b0;
      fifo_rd   = 1'b0;
      if (!en) begin
         nxt_state = TX_IDLE;
         nxt_pend  = 1'b0;
      end else begin
         case (state)
            TX_IDLE: begin
               if (fifo_used != '0) begin
                  nxt_state = TX_SYNC0;
                  nxt_data  = SYNC0;
                  nxt_pend  = 1'b1;
               end
            end
            TX_SYNC0: begin
               if (wr_now) begin
                  nxt_state = TX_SYNC1;
                  nxt_data  = SYNC1;
                  nxt_csum  = '0;
                  nxt_cnt   = '0;
               end
            end
            TX_SYNC1: begin
               if (wr_now) begin
                  nxt_state = TX_LNH;
                  nxt_data  = lines_cnt[15:8];
               end
            end
            TX_LNH: begin
               if (wr_now) begin
                  nxt_state = TX_LNL;
                  nxt_data  = lines_cnt[7:0];
                  nxt_csum  = csum ^ data_r;
               end
            end
            TX_LNL: begin
               if (wr_now) begin
                  nxt_state = TX_LENH;
                  nxt_data  = LEN[15:8];
                  nxt_csum  = csum ^ data_r;
               end
            end
            TX_LENH: begin
               if (wr_now) begin
                  nxt_state = TX_LENL;
                  nxt_data  = LEN[7:0];
                  nxt_csum  = csum ^ data_r;
               end
            end
            TX_LENL: begin
               if (wr_now) begin
                  nxt_state = TX_PIXH;
                  nxt_csum  = csum ^ data_r;
                  do_fetch  = 1'b1;
               end
            end
            TX_PIXH: begin
               if (!pending) begin
                  do_fetch = 1'b1;
               end else if (wr_now) begin
                  nxt_state = TX_PIXL;
                  nxt_data  = lo_byte;
                  nxt_csum  = csum ^ data_r;
               end
            end
            TX_PIXL: begin
               if (wr_now) begin
                  nxt_csum = csum ^ data_r;
                  if (pix_cnt == LAST_PIX) begin
                     nxt_state = TX_CSUM;
                     nxt_data  = csum ^ data_r;
                  end else begin
                     nxt_state = TX_PIXH;
                     nxt_cnt   = pix_cnt + LEN_W'(1);
                     do_fetch  = 1'b1;
                  end
               end
            end
            TX_CSUM: begin
               if (wr_now) begin
                  nxt_state = TX_IDLE;
                  nxt_pend  = 1'b0;
                  nxt_lines = lines_cnt + LINE_NO_W'(1);
               end
            end
            default: begin
               nxt_state = TX_IDLE;
               nxt_pend  = 1'b0;
            end
         endcase
         if (do_fetch) begin
            if (!fifo_empty) begin
               fifo_rd  = 1'b1;
               nxt_data = fifo_rd_data[15:8];
               nxt_lo   = fifo_rd_data[7:0];
               nxt_pend = 1'b1;
            end else begin
               nxt_pend = 1'b0;
            end
         end
      end
   end

   assign tx_wrreq   = wr_now;
   assign tx_data    = data_r;
   assign lines_sent = lines_cnt;
   assign ovf        = ovf_r;
   assign sol_err    = sol_err_r;
   assign busy       = (state != TX_IDLE);

endmodule

// File: doc/usb_tx_framer.md
# usb_tx_framer

Packs the CCD pixel stream into framed byte packets and writes them into the FT232H transmit FIFO, which carries them to the PC. It is the PC-bound counterpart of the command path that reads the receive FIFO. The block sits between the pixel output of `ccd_timing` (already in the `clk_100M` domain) and the `tx_*` FIFO interface of `ft_232h`. It buffers one or more lines so that USB back-pressure does not stall the CCD.

## Interface
- `LINE_PIX`, 5340: pixels per CCD line, which is also the header length field (1..65535).
- `FIFO_DEPTH`, 1024: depth of the pixel buffer in 16-bit words (power of 2).
- `clk_100M`  in  1  system clock. All logic is on this clock.
- `nrst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  scan enable from `control`. Low flushes the buffer and returns to IDLE.
- `pix_valid`  in  1  pixel strobe, one cycle per pixel.
- `pix_sol`  in  1  start of line, qualified by `pix_valid`.
- `pix_data`  in  16  ADC sample.
- `tx_full`  in  1  transmit FIFO full.
- `tx_wrreq`  out  1  write strobe into the transmit FIFO.
- `tx_data`  out  8  byte to write.
- `lines_sent`  out  16  count of completed frames. Wraps.
- `ovf`  out  1  sticky: a pixel was lost because the buffer was full.
- `sol_err`  out  1  sticky: `pix_sol` arrived mid-line.
- `busy`  out  1  framer not in IDLE.

## Operation
- Frame byte order: `0xA5`, `0x5A`, line_no[15:8], line_no[7:0], LINE_PIX[15:8], LINE_PIX[7:0], then each pixel as [15:8] followed by [7:0], then CSUM.
- CSUM is the 8-bit XOR of every byte after the two sync bytes.
- line_no equals `lines_sent` at the moment the frame starts.
- Capture side:
  - Idle until `en && pix_valid && pix_sol`.
  - Then writes exactly LINE_PIX pixels, the SOL pixel included, into `pix_fifo`, and returns to idle.
  - Pixels outside a capture are discarded.
  - A `pix_sol` during a capture sets `sol_err`. That pixel is stored as ordinary data and the count continues.
- Overflow: a capture write while the FIFO is full drops the pixel, sets `ovf`, and halts capture until `en` falls. The framer then stalls inside the frame. Recovery is the host dropping `en`.
- Framer states:
  - IDLE → SYNC0 when `en` and the FIFO is non-empty.
  - Then SYNC1 → LNH → LNL → LENH → LENL → PIXH ⇄ PIXL, repeated LINE_PIX times → CSUM → IDLE.
  - At the CSUM write, `lines_sent` increments.
  - A pixel is popped on entry to PIXH. If the FIFO is empty, the state is held with no write.
- `en` low:
  - The framer goes to IDLE on the next edge, even mid-frame. No trailing bytes are written.
  - The FIFO and the capture counter are cleared.
  - `ovf`, `sol_err` and `lines_sent` clear only on `nrst`.
- Reset values: `tx_wrreq`=0, `tx_data`=0, `lines_sent`=0, `ovf`=0, `sol_err`=0, `busy`=0. Both FSMs are in IDLE and the FIFO is empty.

## Timing
- `tx_data` is registered and holds the current state's byte.
- `tx_wrreq = byte_pending && !tx_full`, where `byte_pending` is a registered signal.
- A byte is written on each edge where `tx_wrreq` is 1, and the state advances on that same edge. If `tx_full` is 1, the state holds and `tx_data` is stable.
- With `tx_full` low, the rate is one byte per cycle.
- A frame with `tx_full` held low takes 6 + 2·LINE_PIX + 1 cycles when the FIFO never starves.
- Latency from the first FIFO word becoming readable to the SYNC0 write is 1 cycle.
- The FIFO read is first-word-fall-through, so PIXH presents `data[15:8]` in the cycle it is entered.
- When a capture write and a framer pop occur in the same cycle, both take effect and the count is unchanged.
- `lines_sent` wraps from 0xFFFF to 0x0000.

## Structure
- `scanner_pkg` holds:
  - the framer state enum `tx_state_t`
  - `SYNC0`/`SYNC1` constants
  - header field widths
- Sub-module `pix_fifo`:
  - synchronous, FWFT, 16 bits wide, parameter FIFO_DEPTH
  - ports for flush, full, empty and used count
- The capture counter and framer FSM are in `usb_tx_framer`.

## Test plan
- Line, no back-pressure: LINE_PIX=4, `en`=1, SOL followed by pixels 0x1234, 0x5678, 0x9ABC, 0xDEF0. Required byte stream: A5 5A 00 00 00 04 12 34 56 78 9A BC DE F0, then CSUM = XOR of bytes 3..14. `lines_sent`=1.
- Back-pressure: same line with `tx_full` pulsed high for 3 cycles during PIXL. Required: no byte lost or duplicated, and `tx_data` stable while full.
- Overflow: FIFO_DEPTH=4, LINE_PIX=8, `tx_full` held high. Required: `ovf`=1 after the 5th pixel and no further writes. Dropping `en` then flushes; `busy`=0 on the next cycle.
- Mid-line SOL: a SOL on pixel 3 of 4. Required: `sol_err`=1, and the frame still contains 4 pixels.
- Reset mid-frame: deassert `nrst` during PIXH. Required: all outputs return to their reset values at once, and the next frame starts with line_no=0.
- Wrap: preload to 65535 frames. Required: the next frame header carries line_no FF FF, and `lines_sent` becomes 0.
